// File: rtl/map_arbiter_if.sv
// Request, response and RAM-side signals of the tile-map arbiter.
// The arbiter takes the slave view; requesters and the RAM take the master view.
interface map_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 3
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_gnt;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;

    logic [1:0]      t_req;
    logic [1:0]      t_op;
    logic [2*AW-1:0] t_addr;
    logic [1:0]      t_gnt;
    logic [1:0]      t_done;
    logic [DW-1:0]   t_rdata;
    logic [1:0]      base_hit;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  vid_req, vid_addr, t_req, t_op, t_addr, mem_rdata,
        output vid_gnt, vid_rvalid, vid_rdata, t_gnt, t_done, t_rdata, base_hit,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output vid_req, vid_addr, t_req, t_op, t_addr, mem_rdata,
        input  vid_gnt, vid_rvalid, vid_rdata, t_gnt, t_done, t_rdata, base_hit,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/map_arbiter.sv
// Serializes video reads and tank read/destroy operations onto the single-port
// tile-map RAM; video has priority, bounded by a streak guard, tanks alternate.
module map_arbiter #(
    parameter int CELLS      = 300,
    parameter int AW         = 9,
    parameter int DW         = 3,
    parameter int VID_STREAK = 4
) (
    input  logic          Clk,
    input  logic          Reset_n,
    map_arbiter_if.slave  bus
);
    localparam int            SW          = $clog2(VID_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX  = SW'(VID_STREAK);
    localparam logic [AW:0]   CELLS_W     = (AW + 1)'(CELLS);
    localparam logic [DW-1:0] CODE_BORDER = DW'(1);
    localparam logic [DW-1:0] CODE_WALL   = DW'(2);
    localparam logic [DW-1:0] CODE_BASE1  = DW'(3);
    localparam logic [DW-1:0] CODE_BASE2  = DW'(4);

    typedef enum logic [1:0] {IDLE, RD, EVAL, WR} state_t;

    state_t        state;
    logic          rr_ptr;
    logic [SW-1:0] streak;
    logic          cur_vid;
    logic          cur_tank;
    logic          cur_op;
    logic          cur_oor;

    logic          any_t;
    logic          vid_win;
    logic          t_win;
    logic          tank_sel;
    logic          gnt_op;
    logic          gnt_oor;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] eval_code;

    function automatic logic [SW-1:0] streak_inc(input logic [SW-1:0] s);
        return (s == STREAK_MAX) ? s : s + 1'b1;
    endfunction

    always_comb begin
        any_t     = |bus.t_req;
        vid_win   = (state == IDLE) && bus.vid_req && !((streak == STREAK_MAX) && any_t);
        tank_sel  = bus.t_req[rr_ptr] ? rr_ptr : ~rr_ptr;
        t_win     = (state == IDLE) && !vid_win && any_t;
        gnt_addr  = vid_win ? bus.vid_addr
                  : (tank_sel ? bus.t_addr[2*AW-1:AW] : bus.t_addr[AW-1:0]);
        gnt_op    = !vid_win && bus.t_op[tank_sel];
        gnt_oor   = ({1'b0, gnt_addr} >= CELLS_W);
        // Out-of-range cells read back as border wall without touching the RAM.
        eval_code = cur_oor ? CODE_BORDER : bus.mem_rdata;
    end

    assign bus.vid_gnt = vid_win;
    assign bus.t_gnt   = t_win ? (tank_sel ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state          <= IDLE;
            rr_ptr         <= 1'b0;
            streak         <= '0;
            cur_vid        <= 1'b0;
            cur_tank       <= 1'b0;
            cur_op         <= 1'b0;
            cur_oor        <= 1'b0;
            bus.vid_rvalid <= 1'b0;
            bus.vid_rdata  <= '0;
            bus.t_done     <= '0;
            bus.t_rdata    <= '0;
            bus.base_hit   <= '0;
            bus.mem_addr   <= '0;
            bus.mem_we     <= 1'b0;
            bus.mem_wdata  <= '0;
        end else begin
            bus.vid_rvalid <= 1'b0;
            bus.t_done     <= '0;
            bus.base_hit   <= '0;
            case (state)
                IDLE: begin
                    if (vid_win && any_t)
                        streak <= streak_inc(streak);
                    else if (t_win || !any_t)
                        streak <= '0;
                    if (vid_win || t_win) begin
                        cur_vid    <= vid_win;
                        cur_tank   <= tank_sel;
                        cur_op     <= gnt_op;
                        cur_oor    <= gnt_oor;
                        bus.mem_we <= 1'b0;
                        if (!gnt_oor)
                            bus.mem_addr <= gnt_addr;
                        if (t_win)
                            rr_ptr <= ~tank_sel;
                        state <= RD;
                    end
                end
                RD: state <= EVAL;
                EVAL: begin
                    // Only a destructible wall needs the write beat; everything else finishes here.
                    if (cur_op && !cur_oor && (eval_code == CODE_WALL)) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_wdata <= '0;
                        state         <= WR;
                    end else begin
                        state <= IDLE;
                        if (cur_vid) begin
                            bus.vid_rvalid <= 1'b1;
                            bus.vid_rdata  <= eval_code;
                        end else begin
                            bus.t_done  <= cur_tank ? 2'b10 : 2'b01;
                            bus.t_rdata <= eval_code;
                        end
                        if (cur_op)
                            bus.base_hit <= {eval_code == CODE_BASE2, eval_code == CODE_BASE1};
                    end
                end
                WR: begin
                    bus.mem_we  <= 1'b0;
                    bus.t_done  <= cur_tank ? 2'b10 : 2'b01;
                    bus.t_rdata <= CODE_WALL;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_map_arbiter.sv
// Bench for map_arbiter: transaction-level model of grants, latencies and map
// contents, compared every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_map_arbiter;
    localparam int CELLS      = 300;
    localparam int AW         = 9;
    localparam int DW         = 3;
    localparam int VID_STREAK = 4;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b1;
    always #10 Clk = ~Clk;

    map_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    map_arbiter #(.CELLS(CELLS), .AW(AW), .DW(DW), .VID_STREAK(VID_STREAK)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic logic [DW-1:0] init_code(input int i);
        if (i >= CELLS) return '0;
        return DW'((i * 7 + 3) % 5);
    endfunction

    // Synchronous single-port map RAM
    logic [DW-1:0] ram [0:511];
    logic          fill_en = 1'b0;
    logic          pl_en   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge Clk) begin
        if (fill_en) begin
            for (int i = 0; i < 512; i++) ram[i] <= init_code(i);
        end else if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Behavioural model state
    logic [DW-1:0] mmem [0:511];
    int  cyc;
    bit  pend, p_vid;
    int  p_tank, p_done, p_we, p_code, p_addr, p_bh;
    int  m_ptr, m_streak, exp_maddr;
    int  glog[$];
    bit  anyt, vwin, twin, wall, at_done, at_we;
    int  tk, op, addr, code;
    logic       last_vgnt;
    logic [1:0] last_tgnt;

    initial begin
        cyc = 0; pend = 0; m_ptr = 0; m_streak = 0; exp_maddr = 0;
        last_vgnt = 0; last_tgnt = 0;
        forever begin
            @(negedge Clk);
            cyc++;
            last_vgnt = bus.vid_gnt;
            last_tgnt = bus.t_gnt;
            if (fill_en) begin
                for (int i = 0; i < 512; i++) mmem[i] = init_code(i);
            end else if (pl_en) begin
                mmem[pl_addr] = pl_data;
            end
            if (!Reset_n) begin
                pend = 0; m_ptr = 0; m_streak = 0; exp_maddr = 0;
                chk("rst_vid_rvalid", int'(bus.vid_rvalid), 0);
                chk("rst_t_done", int'(bus.t_done), 0);
                chk("rst_base_hit", int'(bus.base_hit), 0);
                chk("rst_mem_we", int'(bus.mem_we), 0);
                chk("rst_mem_addr", int'(bus.mem_addr), 0);
            end else begin
                at_done = pend && (cyc == p_done);
                at_we   = pend && (cyc == p_we);
                chk("vid_rvalid", int'(bus.vid_rvalid), int'(at_done && p_vid));
                chk("t_done", int'(bus.t_done), (at_done && !p_vid) ? (1 << p_tank) : 0);
                chk("base_hit", int'(bus.base_hit), at_done ? p_bh : 0);
                chk("mem_we", int'(bus.mem_we), int'(at_we));
                chk("mem_addr", int'(bus.mem_addr), exp_maddr);
                if (at_done && p_vid)  chk("vid_rdata", int'(bus.vid_rdata), p_code);
                if (at_done && !p_vid) chk("t_rdata", int'(bus.t_rdata), p_code);
                if (at_we) begin
                    chk("mem_wdata", int'(bus.mem_wdata), 0);
                    mmem[p_addr] = '0;
                end
                if (pend && cyc >= p_done) pend = 0;
                if (!pend) begin
                    anyt = (bus.t_req != 2'b00);
                    vwin = bus.vid_req && !((m_streak == VID_STREAK) && anyt);
                    twin = !vwin && anyt;
                    tk   = bus.t_req[m_ptr] ? m_ptr : 1 - m_ptr;
                    chk("vid_gnt", int'(bus.vid_gnt), int'(vwin));
                    chk("t_gnt", int'(bus.t_gnt), twin ? (1 << tk) : 0);
                    if (vwin && anyt) m_streak = (m_streak < VID_STREAK) ? m_streak + 1 : VID_STREAK;
                    else if (twin || !anyt) m_streak = 0;
                    if (vwin || twin) begin
                        op   = vwin ? 0 : int'(bus.t_op[tk]);
                        addr = vwin ? int'(bus.vid_addr)
                             : (tk == 1 ? int'(bus.t_addr[2*AW-1:AW]) : int'(bus.t_addr[AW-1:0]));
                        code = (addr >= CELLS) ? 1 : int'(mmem[addr]);
                        wall = (op == 1) && (addr < CELLS) && (code == 2);
                        p_vid  = vwin;
                        p_tank = tk;
                        p_addr = addr;
                        p_code = code;
                        p_bh   = (op == 1 && code == 3) ? 1 : ((op == 1 && code == 4) ? 2 : 0);
                        p_done = cyc + (wall ? 4 : 3);
                        p_we   = wall ? cyc + 3 : -1;
                        pend   = 1;
                        if (addr < CELLS) exp_maddr = addr;
                        if (twin) m_ptr = 1 - tk;
                        glog.push_back(vwin ? 0 : tk + 1);
                    end
                end else begin
                    chk("vid_gnt_busy", int'(bus.vid_gnt), 0);
                    chk("t_gnt_busy", int'(bus.t_gnt), 0);
                end
            end
        end
    end

    // Directed-operation capture, cycles 0..4 after the request goes up
    int r_gnt;
    int r_vrv [5];
    int r_vrd [5];
    int r_done[5];
    int r_trd [5];
    int r_bh  [5];
    int r_we  [5];
    int r_ma  [5];

    task automatic run_op(input int who, input int opv, input int a);
        @(posedge Clk); #1;
        if (who == 0) begin
            bus.vid_req  = 1'b1;
            bus.vid_addr = AW'(a);
        end else begin
            bus.t_req  = (who == 1) ? 2'b01 : 2'b10;
            bus.t_op   = {opv[0], opv[0]};
            bus.t_addr = {AW'(a), AW'(a)};
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            if (c == 0) r_gnt = (who == 0) ? int'(bus.vid_gnt) : int'(bus.t_gnt);
            r_vrv[c]  = int'(bus.vid_rvalid);
            r_vrd[c]  = int'(bus.vid_rdata);
            r_done[c] = int'(bus.t_done);
            r_trd[c]  = int'(bus.t_rdata);
            r_bh[c]   = int'(bus.base_hit);
            r_we[c]   = int'(bus.mem_we);
            r_ma[c]   = int'(bus.mem_addr);
            @(posedge Clk); #1;
            bus.vid_req = 1'b0;
            bus.t_req   = 2'b00;
        end
    endtask

    task automatic preload(input int a, input int d);
        @(posedge Clk); #1;
        pl_en = 1'b1; pl_addr = AW'(a); pl_data = DW'(d);
        @(posedge Clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic refill();
        @(posedge Clk); #1;
        fill_en = 1'b1;
        @(posedge Clk); #1;
        fill_en = 1'b0;
    endtask

    task automatic quiesce();
        @(posedge Clk); #1;
        bus.vid_req = 1'b0;
        bus.t_req   = 2'b00;
        repeat (6) @(posedge Clk);
        #1;
    endtask

    task automatic compare_map(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < CELLS; i++) if (ram[i] !== mmem[i]) bad++;
        chk(name, bad, 0);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 5) return AW'($urandom_range(0, 15));
        if (r < 9) return AW'($urandom_range(16, CELLS - 1));
        return AW'($urandom_range(CELLS, 511));
    endfunction

    function automatic int gl(input int i);
        return (i < glog.size()) ? glog[i] : -1;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_sum;
        bus.vid_req = 1'b0; bus.vid_addr = '0;
        bus.t_req = 2'b00; bus.t_op = 2'b00; bus.t_addr = '0;
        #1 Reset_n = 1'b0;
        refill();
        @(negedge Clk);
        chk("reset mem_addr", int'(bus.mem_addr), 0);
        chk("reset mem_wdata", int'(bus.mem_wdata), 0);
        chk("reset t_rdata", int'(bus.t_rdata), 0);
        chk("reset vid_rdata", int'(bus.vid_rdata), 0);
        chk("reset t_gnt", int'(bus.t_gnt), 0);
        @(posedge Clk); #5 Reset_n = 1'b1;

        // Video read of an empty cell
        preload(21, 0);
        run_op(0, 0, 21);
        chk("vid21 gnt c0", r_gnt, 1);
        chk("vid21 rvalid c2", r_vrv[2], 0);
        chk("vid21 rvalid c3", r_vrv[3], 1);
        chk("vid21 rdata c3", r_vrd[3], 0);
        we_sum = r_we[0] + r_we[1] + r_we[2] + r_we[3] + r_we[4];
        chk("vid21 no write", we_sum, 0);

        // Tank 0 destroys a wall, then video reads it back
        preload(66, 2);
        run_op(1, 1, 66);
        chk("d66 gnt c0", r_gnt, 1);
        chk("d66 we c3", r_we[3], 1);
        chk("d66 addr c3", r_ma[3], 66);
        chk("d66 done c3", r_done[3], 0);
        chk("d66 done c4", r_done[4], 1);
        chk("d66 rdata c4", r_trd[4], 2);
        run_op(0, 0, 66);
        chk("rd66 rdata c3", r_vrd[3], 0);

        // Out-of-range read and destroy
        run_op(1, 0, 300);
        chk("oor300 done c3", r_done[3], 1);
        chk("oor300 rdata", r_trd[3], 1);
        chk("oor300 mem_addr", r_ma[3], 66);
        we_sum = r_we[0] + r_we[1] + r_we[2] + r_we[3] + r_we[4];
        chk("oor300 no write", we_sum, 0);
        run_op(2, 1, 511);
        chk("oor511 done c3", r_done[3], 2);
        chk("oor511 rdata", r_trd[3], 1);
        chk("oor511 mem_addr", r_ma[3], 66);
        chk("oor511 base_hit", r_bh[3], 0);

        // Tank 1 hits a base, then a border wall
        preload(270, 3);
        run_op(2, 1, 270);
        chk("d270 done c3", r_done[3], 2);
        chk("d270 base_hit c3", r_bh[3], 1);
        chk("d270 no write", r_we[3] + r_we[4], 0);
        preload(0, 1);
        run_op(2, 1, 0);
        chk("d0 done c3", r_done[3], 2);
        chk("d0 rdata", r_trd[3], 1);
        chk("d0 base_hit", r_bh[3], 0);
        chk("d0 no write", r_we[3] + r_we[4], 0);

        // Both tanks hold requests: strict alternation from tank 0
        quiesce();
        glog.delete();
        bus.t_req = 2'b11; bus.t_op = 2'b00; bus.t_addr = {AW'(5), AW'(7)};
        for (int k = 0; k < 60 && glog.size() < 4; k++) @(negedge Clk);
        quiesce();
        chk("rr grant0", gl(0), 1);
        chk("rr grant1", gl(1), 2);
        chk("rr grant2", gl(2), 1);
        chk("rr grant3", gl(3), 2);

        // Video and both tanks held: streak guard lets one tank through after 4 video grants
        glog.delete();
        bus.vid_req = 1'b1; bus.vid_addr = AW'(9);
        bus.t_req = 2'b11; bus.t_op = 2'b00;
        for (int k = 0; k < 80 && glog.size() < 6; k++) @(negedge Clk);
        quiesce();
        for (int i = 0; i < 4; i++) chk("streak video grant", gl(i), 0);
        chk("streak tank grant", gl(4), 1);
        chk("streak video resumes", gl(5), 0);

        // Randomized traffic in three rounds, map reloaded between rounds
        for (int round = 0; round < 3; round++) begin
            refill();
            for (int k = 0; k < 1000; k++) begin
                @(posedge Clk); #1;
                if (last_vgnt)    bus.vid_req  = 1'b0;
                if (last_tgnt[0]) bus.t_req[0] = 1'b0;
                if (last_tgnt[1]) bus.t_req[1] = 1'b0;
                if (!bus.vid_req && $urandom_range(0, 2) == 0) begin
                    bus.vid_req  = 1'b1;
                    bus.vid_addr = rand_addr();
                end
                if (!bus.t_req[0] && $urandom_range(0, 2) == 0) begin
                    bus.t_req[0]         = 1'b1;
                    bus.t_op[0]          = 1'($urandom_range(0, 1));
                    bus.t_addr[AW-1:0]   = rand_addr();
                end
                if (!bus.t_req[1] && $urandom_range(0, 2) == 0) begin
                    bus.t_req[1]         = 1'b1;
                    bus.t_op[1]          = 1'($urandom_range(0, 1));
                    bus.t_addr[2*AW-1:AW] = rand_addr();
                end
            end
            quiesce();
            compare_map("map contents after random round");
        end

        // Reset asserted during the write beat of a wall destroy
        preload(100, 2);
        @(posedge Clk); #1;
        bus.t_req = 2'b01; bus.t_op = 2'b01; bus.t_addr = {AW'(0), AW'(100)};
        @(negedge Clk);
        chk("rstwr gnt c0", int'(bus.t_gnt), 1);
        @(posedge Clk); #1;
        bus.t_req = 2'b00;
        @(posedge Clk);
        @(posedge Clk); #1;
        chk("rstwr we in WR", int'(bus.mem_we), 1);
        #1 Reset_n = 1'b0;
        #1;
        chk("rstwr we dropped", int'(bus.mem_we), 0);
        chk("rstwr mem_addr", int'(bus.mem_addr), 0);
        chk("rstwr t_done", int'(bus.t_done), 0);
        chk("rstwr t_rdata", int'(bus.t_rdata), 0);
        chk("rstwr vid_rdata", int'(bus.vid_rdata), 0);
        @(negedge Clk);
        @(posedge Clk); #5 Reset_n = 1'b1;
        run_op(0, 0, 100);
        chk("rstwr cell kept rvalid", r_vrv[3], 1);
        chk("rstwr cell kept code", r_vrd[3], 2);
        quiesce();
        compare_map("map contents after reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
